// File: rtl/hvmux_seq_if.sv
// Bundle between the acquisition FSM / register file, hvmux_seq and hvmuxctl.
// master drives config, control pulses and the mux busy flag; slave is the sequencer.
interface hvmux_seq_if #(
  parameter int SWITCH_N = 16,
  parameter int DEPTH    = 16
);
  localparam int AW = $clog2(DEPTH);

  logic                cfg_wr;
  logic [AW-1:0]       cfg_addr;
  logic [SWITCH_N-1:0] cfg_data;
  logic [AW-1:0]       seq_last;
  logic                seq_loop;
  logic                start;
  logic                stop;
  logic                trig;
  logic [SWITCH_N-1:0] hv_din;
  logic                hv_dvalid;
  logic                hv_busy;
  logic                ready;
  logic [AW-1:0]       idx;
  logic                active;
  logic                done;
  logic                overrun;

  modport master (
    output cfg_wr, cfg_addr, cfg_data, seq_last, seq_loop, start, stop, trig, hv_busy,
    input  hv_din, hv_dvalid, ready, idx, active, done, overrun
  );

  modport slave (
    input  cfg_wr, cfg_addr, cfg_data, seq_last, seq_loop, start, stop, trig, hv_busy,
    output hv_din, hv_dvalid, ready, idx, active, done, overrun
  );
endinterface

// File: rtl/hvmux_seq.sv
// Steps hvmuxctl through a table of switch patterns, one pattern per acquisition shot.
// Every started SPI load is allowed to finish before the sequencer goes idle.
module hvmux_seq #(
  parameter int SWITCH_N  = 16,
  parameter int DEPTH     = 16,
  parameter int GUARD_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  hvmux_seq_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_SEND, S_GUARD, S_WAIT, S_ARMED
  } state_t;

  state_t              r_state;
  logic [SWITCH_N-1:0] r_mem [DEPTH];
  logic [AW-1:0]       r_idx;
  logic [AW-1:0]       r_last;
  logic                r_loop;
  logic                r_stop_pend;
  logic [GW-1:0]       r_gcnt;
  logic [SWITCH_N-1:0] r_din;
  logic                r_dvalid;
  logic                r_ready;
  logic                r_active;
  logic                r_done;
  logic                r_overrun;

  logic w_xfer;
  logic w_wrap;
  logic w_to_idle;

  // Pattern table has no reset; a read in the same cycle as a write sees the old word.
  always_ff @(posedge clk) begin
    if (bus.cfg_wr) r_mem[bus.cfg_addr] <= bus.cfg_data;
  end

  always_comb begin
    w_xfer    = (r_state == S_FETCH) || (r_state == S_SEND) ||
                (r_state == S_GUARD) || (r_state == S_WAIT);
    w_wrap    = (r_idx == r_last);
    w_to_idle = 1'b0;
    if (r_state == S_WAIT && !bus.hv_busy && (r_stop_pend || bus.stop))
      w_to_idle = 1'b1;
    // stop beats trig when both land in the same armed cycle
    if (r_state == S_ARMED && (bus.stop || (bus.trig && w_wrap && !r_loop)))
      w_to_idle = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_last      <= '0;
      r_loop      <= 1'b0;
      r_stop_pend <= 1'b0;
      r_gcnt      <= '0;
      r_din       <= '0;
      r_dvalid    <= 1'b0;
      r_ready     <= 1'b0;
      r_active    <= 1'b0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_dvalid <= 1'b0;
      r_done   <= 1'b0;
      if (w_xfer && bus.trig) r_overrun   <= 1'b1;
      if (w_xfer && bus.stop) r_stop_pend <= 1'b1;

      if (w_to_idle) begin
        r_state     <= S_IDLE;
        r_done      <= 1'b1;
        r_active    <= 1'b0;
        r_ready     <= 1'b0;
        r_idx       <= '0;
        r_stop_pend <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              r_idx       <= '0;
              r_last      <= bus.seq_last;
              r_loop      <= bus.seq_loop;
              r_overrun   <= 1'b0;
              r_stop_pend <= 1'b0;
              r_active    <= 1'b1;
              r_state     <= S_FETCH;
            end
          end
          // hv_din is the table's read register, so the load pulse lines up with it
          S_FETCH: begin
            r_din    <= r_mem[r_idx];
            r_dvalid <= 1'b1;
            r_state  <= S_SEND;
          end
          S_SEND: begin
            r_gcnt  <= GW'(GUARD_CYC - 1);
            r_state <= S_GUARD;
          end
          // hvmuxctl may not have raised busy yet right after the load pulse
          S_GUARD: begin
            if (r_gcnt == '0) r_state <= S_WAIT;
            else              r_gcnt  <= r_gcnt - 1'b1;
          end
          S_WAIT: begin
            if (!bus.hv_busy) begin
              r_ready <= 1'b1;
              r_state <= S_ARMED;
            end
          end
          S_ARMED: begin
            if (bus.trig) begin
              r_ready <= 1'b0;
              r_idx   <= w_wrap ? '0 : r_idx + AW'(1);
              r_state <= S_FETCH;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.hv_din    = r_din;
  assign bus.hv_dvalid = r_dvalid;
  assign bus.ready     = r_ready;
  assign bus.idx       = r_idx;
  assign bus.active    = r_active;
  assign bus.done      = r_done;
  assign bus.overrun   = r_overrun;
endmodule

// File: tb/tb_hvmux_seq.sv
// Bench for hvmux_seq: a max14866-style mux model, expected-pattern queue and monitor.
module tb_hvmux_seq;
  localparam int SWITCH_N  = 16;
  localparam int DEPTH     = 16;
  localparam int GUARD_CYC = 2;
  localparam int SPI_CYC   = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hvmux_seq_if #(.SWITCH_N(SWITCH_N), .DEPTH(DEPTH)) bus ();

  hvmux_seq #(.SWITCH_N(SWITCH_N), .DEPTH(DEPTH), .GUARD_CYC(GUARD_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Mux model: busy for SPI_CYC cycles after a load pulse, switches latch as busy falls.
  logic        m_busy  = 1'b0;
  logic [15:0] m_shift = '0;
  logic [15:0] m_sw    = '0;
  int          m_cnt   = 0;
  assign bus.hv_busy = m_busy;

  always @(posedge clk) begin
    if (bus.hv_dvalid) begin
      m_shift <= bus.hv_din;
      m_cnt   <= SPI_CYC;
      m_busy  <= 1'b1;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        m_sw   <= m_shift;
      end
    end
  end

  int          checks   = 0;
  int          fails    = 0;
  int          dv_count = 0;
  logic [15:0] exp_q[$];
  logic [15:0] last_exp = '0;
  logic        prev_ready = 1'b0;
  logic [15:0] pat [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (bus.hv_dvalid) begin
        dv_count++;
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL dvalid_unexpected actual=%h required=no_pulse", bus.hv_din);
        end else begin
          last_exp = exp_q.pop_front();
          chk("dvalid_din", {16'h0, bus.hv_din}, {16'h0, last_exp});
        end
      end
      if (bus.ready && !prev_ready) chk("ready_switch_state", {16'h0, m_sw}, {16'h0, last_exp});
      prev_ready = bus.ready;
    end
  endtask

  task automatic pulse(input bit s, input bit p, input bit t);
    @(negedge clk);
    bus.start = s; bus.stop = p; bus.trig = t;
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0; bus.trig = 1'b0;
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    @(negedge clk);
    bus.cfg_wr = 1'b1; bus.cfg_addr = 4'(a); bus.cfg_data = d;
    @(negedge clk);
    bus.cfg_wr = 1'b0;
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!bus.ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(nm, {31'h0, bus.ready}, 32'h1);
  endtask

  task automatic wait_unbusy();
    int n = 0;
    while (bus.hv_busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("busy_fall_timeout", {31'h0, bus.hv_busy}, 32'h0);
  endtask

  function automatic logic [31:0] outs();
    return {8'h0, bus.hv_din, bus.hv_dvalid, bus.ready, bus.idx, bus.active, bus.done, bus.overrun};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int ei;
    pat[0] = 16'hFFFF; pat[1] = 16'h5555; pat[2] = 16'hAAAA; pat[3] = 16'h1234;
    bus.cfg_wr = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.seq_last = '0; bus.seq_loop = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.trig = 1'b0;
    fork monitor(); join_none

    repeat (2) @(negedge clk);
    chk("reset_outputs", outs(), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) wr(i, pat[i]);

    // T1: start latency and first pattern
    bus.seq_last = 4'd2; bus.seq_loop = 1'b0;
    exp_q.push_back(pat[0]);
    pulse(1, 0, 0);
    chk("t1_active", {31'h0, bus.active}, 32'h1);
    @(negedge clk);
    chk("t1_dvalid_latency", {31'h0, bus.hv_dvalid}, 32'h1);
    @(negedge clk);
    chk("t1_dvalid_width", {31'h0, bus.hv_dvalid}, 32'h0);
    wait_ready("t1_ready");

    // T2: advance through entries 1,2 then finish
    for (int k = 1; k <= 2; k++) begin
      exp_q.push_back(pat[k]);
      pulse(0, 0, 1);
      chk("t2_idx", {28'h0, bus.idx}, 32'(k));
      chk("t2_ready_drop", {31'h0, bus.ready}, 32'h0);
      @(negedge clk);
      chk("t2_trig_latency", {31'h0, bus.hv_dvalid}, 32'h1);
      wait_ready("t2_ready");
    end
    pulse(0, 0, 1);
    chk("t2_done", {31'h0, bus.done}, 32'h1);
    chk("t2_idle_state", {30'h0, bus.active, bus.ready}, 32'h0);
    chk("t2_idx_zero", {28'h0, bus.idx}, 32'h0);
    @(negedge clk);
    chk("t2_done_width", {31'h0, bus.done}, 32'h0);
    chk("t2_dvalid_total", 32'(dv_count), 32'd3);

    // T3: loop over two entries
    bus.seq_last = 4'd1; bus.seq_loop = 1'b1;
    exp_q.push_back(pat[0]);
    pulse(1, 0, 0);
    wait_ready("t3_ready0");
    ei = 0;
    for (int k = 0; k < 5; k++) begin
      ei = (ei == 1) ? 0 : 1;
      exp_q.push_back(pat[ei]);
      pulse(0, 0, 1);
      chk("t3_idx", {28'h0, bus.idx}, 32'(ei));
      wait_ready("t3_ready");
    end
    pulse(0, 1, 0);
    chk("t3_stop_done", {30'h0, bus.done, bus.active}, 32'h2);
    chk("t3_dvalid_total", 32'(dv_count), 32'd9);

    // T4: trig during GUARD and WAIT
    bus.seq_last = 4'd2; bus.seq_loop = 1'b0;
    exp_q.push_back(pat[0]);
    pulse(1, 0, 0);
    @(negedge clk);
    pulse(0, 0, 1);
    chk("t4_overrun_guard", {31'h0, bus.overrun}, 32'h1);
    chk("t4_idx_guard", {28'h0, bus.idx}, 32'h0);
    pulse(0, 0, 1);
    wait_ready("t4_ready");
    chk("t4_overrun_sticky", {31'h0, bus.overrun}, 32'h1);
    chk("t4_idx_kept", {28'h0, bus.idx}, 32'h0);
    chk("t4_dvalid_total", 32'(dv_count), 32'd10);

    // T5a: stop while the transfer is in flight
    exp_q.push_back(pat[1]);
    pulse(0, 0, 1);
    @(negedge clk);
    pulse(0, 1, 0);
    wait_unbusy();
    chk("t5_not_done_yet", {31'h0, bus.done}, 32'h0);
    @(negedge clk);
    chk("t5_stop_done", {29'h0, bus.done, bus.active, bus.ready}, 32'h4);
    chk("t5_mux_completed", {16'h0, m_sw}, {16'h0, pat[1]});
    repeat (4) @(negedge clk);
    chk("t5_no_more_dvalid", 32'(dv_count), 32'd11);

    // T4b / T5b: start clears overrun; stop+trig in ARMED
    chk("t4_overrun_held_idle", {31'h0, bus.overrun}, 32'h1);
    exp_q.push_back(pat[0]);
    pulse(1, 0, 0);
    chk("t4_start_clears_overrun", {31'h0, bus.overrun}, 32'h0);
    wait_ready("t5_ready0");
    exp_q.push_back(pat[1]);
    pulse(0, 0, 1);
    wait_ready("t5_ready1");
    chk("t5_idx1", {28'h0, bus.idx}, 32'h1);
    pulse(0, 1, 1);
    chk("t5_stop_wins", {29'h0, bus.done, bus.active, bus.ready}, 32'h4);
    chk("t5_idx_reset", {28'h0, bus.idx}, 32'h0);
    repeat (4) @(negedge clk);
    chk("t5_no_advance", 32'(dv_count), 32'd13);

    // T6: async reset mid-WAIT, then replay from entry 0
    exp_q.push_back(pat[0]);
    pulse(1, 0, 0);
    wait_ready("t6_ready0");
    exp_q.push_back(pat[1]);
    pulse(0, 0, 1);
    repeat (4) @(negedge clk);
    chk("t6_pre_reset_active", {31'h0, bus.active}, 32'h1);
    #2 rst_n = 1'b0;
    #1 chk("t6_async_reset", outs(), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_unbusy();
    exp_q.push_back(pat[0]);
    pulse(1, 0, 0);
    wait_ready("t6_replay_ready");
    exp_q.push_back(pat[1]);
    pulse(0, 0, 1);
    wait_ready("t6_replay_ready1");
    pulse(0, 1, 0);
    chk("t6_stop_done", {30'h0, bus.done, bus.active}, 32'h2);
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
